// File: rtl/mul_ace_pkg.sv
// Shared types and constants for the mul_ace sequential multiply responder.
// State encoding, default geometry and the uio pin map used by the tt_um_ wrapper.
package mul_ace_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int TRUNC_DEF = 2;

  // uio bit positions at the tt_um_ top
  localparam int REQ_BIT  = 0;
  localparam int ACK_BIT  = 1;
  localparam int VLD_BIT  = 2;
  localparam int BUSY_BIT = 3;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    MUL    = 3'd2,
    OUT_LO = 3'd3,
    OUT_HI = 3'd4
  } state_e;

endpackage

// File: rtl/mul_ace_seq_responder_if.sv
// Host-side pin bundle of the multiply responder: operand bytes in, product beats out.
// master = host/initiator, slave = responder.
interface mul_ace_seq_responder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             req;
  logic             ack;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             busy;

  modport master (output data_in, output req,
                  input ack, input data_out, input out_valid, input busy);
  modport slave  (input data_in, input req,
                  output ack, output data_out, output out_valid, output busy);
endinterface

// File: rtl/mul_ace_shift_add.sv
// WIDTH-step shift-add multiplier: start loads B and clears P, then one partial product per run cycle.
// done is high during the final step; p_fin_lo is the low half P will hold after that step.
module mul_ace_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               start,
  input  logic               run,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic [WIDTH-1:0]   p_fin_lo,
  output logic               done
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   b_q,   b_d;
  logic [2*WIDTH-1:0] p_q,   p_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    b_d   = b_q;
    p_d   = p_q;
    cnt_d = cnt_q;
    done  = 1'b0;
    if (start) begin
      b_d   = b;
      p_d   = '0;
      cnt_d = '0;
    end else if (run) begin
      if (b_q[0]) begin
        p_d = p_q + ({{WIDTH{1'b0}}, a} << cnt_q);
      end
      b_d   = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
      done  = (cnt_q == CNT_W'(WIDTH - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
    end else if (en) begin
      b_q   <= b_d;
      p_q   <= p_d;
      cnt_q <= cnt_d;
    end
  end

  assign p        = p_q;
  assign p_fin_lo = p_d[WIDTH-1:0];
endmodule

// File: rtl/mul_ace_seq_responder.sv
// 4-phase req/ack responder: capture A, B; shift-add multiply; return product low beat then high beat.
// MUL_ACE_APPROX_EN: operand A captured with its TRUNC low bits forced to zero.
module mul_ace_seq_responder
  import mul_ace_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TRUNC = TRUNC_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  mul_ace_seq_responder_if.slave bus
);
  state_e           state_q, state_d;
  logic             req_s1_q, req_s2_q;
  logic             ack_q, ack_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] a_capt;

  logic               start, run, done, accept;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   p_fin_lo;

`ifdef MUL_ACE_APPROX_EN
  assign a_capt = (bus.data_in >> TRUNC) << TRUNC;
`else
  localparam int unused_trunc = TRUNC;
  assign a_capt = bus.data_in;
`endif

  // A fresh accept requires ack low, so a held req cannot capture twice.
  assign accept = req_s2_q && !ack_q && (state_q != MUL);
  assign run    = (state_q == MUL);

  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    op_a_d      = op_a_q;
    start       = 1'b0;
    if (!req_s2_q) ack_d = 1'b0;
    case (state_q)
      LOAD_A: if (accept) begin
        ack_d   = 1'b1;
        op_a_d  = a_capt;
        state_d = LOAD_B;
      end
      LOAD_B: if (accept) begin
        ack_d   = 1'b1;
        start   = 1'b1;
        state_d = MUL;
      end
      MUL: if (done) begin
        state_d     = OUT_LO;
        out_valid_d = 1'b1;
        data_out_d  = p_fin_lo;
      end
      OUT_LO: if (accept) begin
        ack_d      = 1'b1;
        data_out_d = p[2*WIDTH-1:WIDTH];
        state_d    = OUT_HI;
      end
      OUT_HI: if (accept) begin
        ack_d       = 1'b1;
        out_valid_d = 1'b0;
        state_d     = LOAD_A;
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      req_s1_q    <= 1'b0;
      req_s2_q    <= 1'b0;
      ack_q       <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      op_a_q      <= '0;
    end else if (ena) begin
      state_q     <= state_d;
      req_s1_q    <= bus.req;
      req_s2_q    <= req_s1_q;
      ack_q       <= ack_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      op_a_q      <= op_a_d;
    end
  end

  mul_ace_shift_add #(.WIDTH(WIDTH)) u_shift_add (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (ena),
    .start    (start),
    .run      (run),
    .a        (op_a_q),
    .b        (bus.data_in),
    .p        (p),
    .p_fin_lo (p_fin_lo),
    .done     (done)
  );

  assign bus.ack       = ack_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == MUL);
  assign bus.data_out  = data_out_q;
endmodule

// File: tb/tb_mul_ace_seq_responder.sv
// Bench for mul_ace_seq_responder: directed vector table, handshake/reset/freeze sequences, random products.
module tb_mul_ace_seq_responder;
  import mul_ace_pkg::*;

  localparam int W  = 8;
  localparam int TR = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic ena   = 1'b1;
  always #5 clk = ~clk;

  mul_ace_seq_responder_if #(.WIDTH(W)) bus ();

  mul_ace_seq_responder #(.WIDTH(W), .TRUNC(TR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;

  always @(negedge clk) if (bus.busy === 1'b1) busy_cnt++;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer product, A optionally rounded down to a multiple of 2**TR.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    int ae;
    ae = a;
`ifdef MUL_ACE_APPROX_EN
    ae = (ae / (1 << TR)) * (1 << TR);
`endif
    return 16'(ae * int'(b));
  endfunction

  task automatic wait_ack(input logic val, input string name);
    int n = 0;
    while (bus.ack !== val && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.ack !== val) begin
      checks++;
      errors++;
      $display("FAIL %s: ack stuck at %b, expected %b", name, bus.ack, val);
    end
  endtask

  task automatic host_write(input logic [7:0] d);
    @(negedge clk);
    bus.data_in = d;
    bus.req     = 1'b1;
    wait_ack(1'b1, "write_ack_rise");
    bus.req = 1'b0;
    wait_ack(1'b0, "write_ack_fall");
  endtask

  task automatic host_read(output logic [7:0] d);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.out_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL read_valid: out_valid stuck at %b, expected 1", bus.out_valid);
    end
    d       = bus.data_out;
    bus.req = 1'b1;
    wait_ack(1'b1, "read_ack_rise");
    bus.req = 1'b0;
    wait_ack(1'b0, "read_ack_fall");
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, output logic [15:0] prod);
    logic [7:0] lo, hi;
    host_write(a);
    host_write(b);
    host_read(lo);
    host_read(hi);
    prod = {hi, lo};
  endtask

  initial begin
    vec_t        vecs[4];
    logic [15:0] prod;
    logic [7:0]  lo, hi, ra, rb;
    int          n;

`ifdef MUL_ACE_APPROX_EN
    vecs[0] = '{8'hFF, 8'hFF, 16'hFB04};
    vecs[1] = '{8'h00, 8'hA7, 16'h0000};
    vecs[2] = '{8'h80, 8'h02, 16'h0100};
    vecs[3] = '{8'h0D, 8'h0B, 16'h0084};
`else
    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{8'h00, 8'hA7, 16'h0000};
    vecs[2] = '{8'h80, 8'h02, 16'h0100};
    vecs[3] = '{8'h0D, 8'h0B, 16'h008F};
`endif

    bus.data_in = '0;
    bus.req     = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(LOAD_A));
    rst_n = 1'b1;
    @(negedge clk);

    // 3 x 5: ack latency, out_valid latency, busy width, beats
    bus.data_in = 8'd3;
    bus.req     = 1'b1;
    n = 0;
    while (bus.ack !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ack_latency", 32'(n), 32'd3);
    bus.req = 1'b0;
    wait_ack(1'b0, "t1_a_fall");
    busy_cnt    = 0;
    bus.data_in = 8'd5;
    bus.req     = 1'b1;
    wait_ack(1'b1, "t1_b_rise");
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("valid_latency", 32'(n), 32'(W));
    bus.req = 1'b0;
    wait_ack(1'b0, "t1_b_fall");
    host_read(lo);
    host_read(hi);
    check("busy_cycles", 32'(busy_cnt), 32'(W));
`ifdef MUL_ACE_APPROX_EN
    check("t1_product", 32'({hi, lo}), 32'h0000);
`else
    check("t1_product", 32'({hi, lo}), 32'h000F);
`endif
    check("t1_state", 32'(dut.state_q), 32'(LOAD_A));
    check("t1_valid_low", 32'(bus.out_valid), 32'd0);
    check("t1_data_hold", 32'(bus.data_out), 32'(hi));

    for (int i = 0; i < 4; i++) begin
      run_txn(vecs[i].a, vecs[i].b, prod);
      check($sformatf("vec%0d", i), 32'(prod), 32'(vecs[i].exp));
    end

    // req held high in LOAD_A: one capture only
    @(negedge clk);
    bus.data_in = 8'h11;
    bus.req     = 1'b1;
    repeat (20) @(negedge clk);
    check("hold_state", 32'(dut.state_q), 32'(LOAD_B));
    check("hold_ack", 32'(bus.ack), 32'd1);
    bus.req = 1'b0;
    wait_ack(1'b0, "hold_fall");
    check("hold_state_after", 32'(dut.state_q), 32'(LOAD_B));
    host_write(8'h03);
    host_read(lo);
    host_read(hi);
`ifdef MUL_ACE_APPROX_EN
    check("hold_product", 32'({hi, lo}), 32'h0030);
`else
    check("hold_product", 32'({hi, lo}), 32'h0033);
`endif

    // async reset mid-multiply
    host_write(8'h9C);
    host_write(8'h77);
    @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ack", 32'(bus.ack), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'(LOAD_A));
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(8'd7, 8'd6, prod);
`ifdef MUL_ACE_APPROX_EN
    check("post_rst_product", 32'(prod), 32'h0018);
`else
    check("post_rst_product", 32'(prod), 32'h002A);
`endif

    // ena low freezes the multiply
    host_write(8'h5A);
    host_write(8'h3C);
    ena = 1'b0;
    repeat (10) @(negedge clk);
    check("freeze_busy", 32'(bus.busy), 32'd1);
    check("freeze_valid", 32'(bus.out_valid), 32'd0);
    ena = 1'b1;
    host_read(lo);
    host_read(hi);
    check("freeze_product", 32'({hi, lo}), 32'(model(8'h5A, 8'h3C)));

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_txn(ra, rb, prod);
      check($sformatf("rand%0d_%0h_%0h", i, ra, rb), 32'(prod), 32'(model(ra, rb)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
